// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: forward-select encoding, shadow stage record,
// hazard FSM states and a register-write match helper.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  // Operand mux select; the 1xx codes are never produced.
  typedef enum logic [2:0] {
    FWD_RF         = 3'b000,
    FWD_EXMEM_ALU  = 3'b001,
    FWD_WB         = 3'b010,
    FWD_EXMEM_UP16 = 3'b011
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    regbits_t rs;
    regbits_t rt;
    logic     use_rs;
    logic     use_rt;
    regbits_t wsel;
    logic     regwen;
    logic     memread;
    logic     lui;
  } shadow_stage_t;

  typedef enum logic {
    RUN     = 1'b0,
    STALLED = 1'b1
  } hzd_state_t;

  localparam shadow_stage_t BUBBLE = '0;

  // True when the stage will write register r; r0 is never a forwarding source.
  function automatic logic stage_writes(input shadow_stage_t s, input regbits_t r);
    return s.valid && s.regwen && (s.wsel != '0) && (s.wsel == r);
  endfunction

endpackage

// File: rtl/fwd_sel_logic.sv
// Forward-select match and priority for one EX operand (MEM over WB).
module fwd_sel_logic
  import cpu_types_pkg::*;
(
  input  logic          ex_valid_i,
  input  logic          ex_use_i,
  input  regbits_t      ex_src_i,
  input  shadow_stage_t mem_i,
  input  shadow_stage_t wb_i,
  output fwd_sel_t      sel_o
);

  // Youngest producer wins; LUI in MEM supplies its upper16 value.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_valid_i && ex_use_i) begin
      if (stage_writes(mem_i, ex_src_i)) begin
        sel_o = mem_i.lui ? FWD_EXMEM_UP16 : FWD_EXMEM_ALU;
      end else if (stage_writes(wb_i, ex_src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding control and load-use stall generation. Keeps a shadow
// of EX/MEM/WB destination info advancing with the pipeline enable.
// Handshake: none; pipe_en is a global advance strobe, every register holds
// while it is low, and stall is combinational so it meets the consumer in decode.
module fwd_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int CNTW    = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               pipe_en,
  input  logic               flush,
  input  logic               dec_valid,
  input  logic [REGBITS-1:0] dec_rs,
  input  logic [REGBITS-1:0] dec_rt,
  input  logic               dec_use_rs,
  input  logic               dec_use_rt,
  input  logic [REGBITS-1:0] dec_wsel,
  input  logic               dec_regwen,
  input  logic               dec_memread,
  input  logic               dec_lui,
  output logic [2:0]         forwarda,
  output logic [2:0]         forwardb,
  output logic               stall,
  output logic [CNTW-1:0]    stall_count,
  output hzd_state_t         dbg_state
);

  shadow_stage_t ex_q, mem_q, wb_q, ex_d;
  hzd_state_t    state_q;
  logic [CNTW-1:0] cnt_q;
  logic          hazard;
  fwd_sel_t      sel_a, sel_b;

  // Next EX entry: the decode instruction, or a bubble when stalled/flushed.
  always_comb begin
    ex_d = BUBBLE;
    if (dec_valid && !stall && !flush) begin
      ex_d.valid   = 1'b1;
      ex_d.rs      = dec_rs;
      ex_d.rt      = dec_rt;
      ex_d.use_rs  = dec_use_rs;
      ex_d.use_rt  = dec_use_rt;
      ex_d.wsel    = dec_wsel;
      ex_d.regwen  = dec_regwen;
      ex_d.memread = dec_memread;
      ex_d.lui     = dec_lui;
    end
  end

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    hazard = dec_valid && ex_q.valid && ex_q.memread && (ex_q.wsel != '0) &&
             ((dec_use_rs && (dec_rs == ex_q.wsel)) ||
              (dec_use_rt && (dec_rt == ex_q.wsel)));
  end

  // Flush beats a hazard; after one stall cycle the load sits in MEM.
  assign stall = (state_q == RUN) && hazard && !flush;

  // Shadow pipeline advances only with the global enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (pipe_en) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  // Hazard FSM: one STALLED cycle per inserted bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else if (pipe_en) begin
      case (state_q)
        RUN:     if (stall) state_q <= STALLED;
        STALLED: state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Count load-use stall cycles that actually took effect; wraps naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (pipe_en && stall) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  fwd_sel_logic u_sel_a (
    .ex_valid_i (ex_q.valid),
    .ex_use_i   (ex_q.use_rs),
    .ex_src_i   (ex_q.rs),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (sel_a)
  );

  fwd_sel_logic u_sel_b (
    .ex_valid_i (ex_q.valid),
    .ex_use_i   (ex_q.use_rt),
    .ex_src_i   (ex_q.rt),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (sel_b)
  );

  assign forwarda    = sel_a;
  assign forwardb    = sel_b;
  assign stall_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with hand-computed expected values.
module tb_fwd_hazard_ctrl;
  import cpu_types_pkg::*;

  logic        CLK, RST, pipe_en, flush;
  logic        dec_valid, dec_use_rs, dec_use_rt;
  logic [4:0]  dec_rs, dec_rt, dec_wsel;
  logic        dec_regwen, dec_memread, dec_lui;
  logic [2:0]  forwarda, forwardb;
  logic        stall;
  logic [31:0] stall_count;
  hzd_state_t  dbg_state;

  int tests = 0;
  int fails = 0;

  fwd_hazard_ctrl #(.REGBITS(5), .CNTW(32)) dut (
    .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_wsel(dec_wsel),
    .dec_regwen(dec_regwen), .dec_memread(dec_memread), .dec_lui(dec_lui),
    .forwarda(forwarda), .forwardb(forwardb), .stall(stall),
    .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] wd,
                       input logic wen, input logic mr, input logic lu);
    dec_valid = v; dec_rs = rs; dec_use_rs = urs; dec_rt = rt; dec_use_rt = urt;
    dec_wsel = wd; dec_regwen = wen; dec_memread = mr; dec_lui = lu;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; pipe_en = 1'b1; flush = 1'b0;
    nop();
    tick(); tick();
    check("rst_fa", forwarda, 0);
    check("rst_fb", forwardb, 0);
    check("rst_stall", stall, 0);
    check("rst_cnt", stall_count, 0);
    check("rst_state", dbg_state, RUN);
    RST = 1'b0;
    tick();

    // add r3,r1,r2 ; add r8,r3,r9 -> A from EX/MEM alu
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd3, 1, 5'd9, 1, 5'd8, 1, 0, 0); tick();
    check("alu_fa", forwarda, 3'b001);
    check("alu_fb", forwardb, 3'b000);
    drain();

    // add r3 ; consumer reads r3 only on rt
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd9, 1, 5'd3, 1, 5'd8, 1, 0, 0); tick();
    check("alub_fa", forwarda, 3'b000);
    check("alub_fb", forwardb, 3'b001);
    drain();

    // add r3 ; consumer names r3 as rs but does not read it
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd3, 0, 5'd9, 1, 5'd8, 1, 0, 0); tick();
    check("nouse_fa", forwarda, 3'b000);
    drain();

    // lui r4 ; or r5,r4,r4 -> upper16 on both
    drive(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 1); tick();
    drive(1, 5'd4, 1, 5'd4, 1, 5'd5, 1, 0, 0); tick();
    check("lui_fa", forwarda, 3'b011);
    check("lui_fb", forwardb, 3'b011);
    drain();

    // lui r4 ; nop ; or r5,r4,r4 -> WB on both
    drive(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 1); tick();
    nop(); tick();
    drive(1, 5'd4, 1, 5'd4, 1, 5'd5, 1, 0, 0); tick();
    check("wb_fa", forwarda, 3'b010);
    check("wb_fb", forwardb, 3'b010);
    drain();

    // add r2 ; add r2 ; consumer of r2 -> MEM beats WB
    drive(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 0); tick();
    drive(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 0); tick();
    drive(1, 5'd2, 1, 5'd11, 1, 5'd10, 1, 0, 0); tick();
    check("prio_fa", forwarda, 3'b001);
    check("prio_fb", forwardb, 3'b000);
    drain();

    // add r0 ; consumer of r0 -> never forwarded
    drive(1, 5'd1, 1, 5'd1, 1, 5'd0, 1, 0, 0); tick();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0); tick();
    check("r0_fa", forwarda, 3'b000);
    check("r0_fb", forwardb, 3'b000);
    drain();

    // lw r6 ; add r7,r6,r1 with flush the same cycle -> no stall, bubble
    drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0); tick();
    flush = 1'b1;
    drive(1, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0, 0);
    check("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    nop();
    check("flush_fa", forwarda, 3'b000);
    check("flush_cnt", stall_count, 0);
    check("flush_state", dbg_state, RUN);
    drain();

    // lw r6 ; add r7,r6,r1 -> one stall cycle, then WB forward
    drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0); tick();
    drive(1, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0, 0);
    check("lu_stall", stall, 1);
    tick();
    check("lu_stall_off", stall, 0);
    check("lu_state", dbg_state, STALLED);
    check("lu_cnt", stall_count, 1);
    check("lu_ld_mem_fa", forwarda, 3'b000);
    tick();
    nop();
    check("lu_fa", forwarda, 3'b010);
    check("lu_fb", forwardb, 3'b000);
    check("lu_cnt_hold", stall_count, 1);
    check("lu_state_run", dbg_state, RUN);
    drain();

    // load-use under a 3-cycle freeze
    drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0); tick();
    drive(1, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0, 0);
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_stall", stall, 1);
      check("frz_cnt", stall_count, 1);
      check("frz_state", dbg_state, RUN);
    end
    pipe_en = 1'b1;
    tick();
    check("frz_cnt_inc", stall_count, 2);
    check("frz_stall_off", stall, 0);
    tick();
    nop();
    check("frz_fa", forwarda, 3'b010);
    drain();

    // reset while STALLED discards everything
    drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0); tick();
    drive(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0, 0); tick();
    check("rs_pre_state", dbg_state, STALLED);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    nop();
    check("rs_stall", stall, 0);
    check("rs_fa", forwarda, 3'b000);
    check("rs_fb", forwardb, 3'b000);
    check("rs_cnt", stall_count, 0);
    check("rs_state", dbg_state, RUN);
    drive(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0, 0);
    check("rs_no_hazard", stall, 0);
    tick();
    nop();
    check("rs_fwd_a", forwarda, 3'b000);
    check("rs_fwd_b", forwardb, 3'b000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
